// File: rtl/activation_lut_loader.sv
// Double-buffered activation LUT: streamed loads fill the shadow bank, then the banks swap atomically.
// Optional `LUT_LOADER_CHECKSUM_EN adds a 16-bit sum of the words accepted in the last completed load.
module activation_lut_loader #(
  parameter string LUT_FILE   = "sigmoid_lut.mem",
  parameter int    ADDR_WIDTH = 8,
  parameter int    DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  active_bank,
`ifdef LUT_LOADER_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, SWAP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_next;
  logic                  transfer;
  logic                  last_word;

  logic [DATA_WIDTH-1:0] bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] bank1 [DEPTH];

  // wr_ready is a registered copy of (state == LOAD), so it qualifies a transfer on its own
  assign transfer  = wr_ready && wr_valid;
  assign last_word = (wr_addr == '1);

  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = LOAD;
          wr_addr_next = '0;
        end
      end
      LOAD: begin
        if (transfer) begin
          wr_addr_next = wr_addr + 1'b1;
          if (last_word) state_next = SWAP;
        end
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      wr_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      active_bank <= 1'b0;
      data_out    <= '0;
    end else begin
      state    <= state_next;
      wr_addr  <= wr_addr_next;
      wr_ready <= (state_next == LOAD);
      busy     <= (state_next != IDLE);
      done     <= (state == SWAP);
      if (state == SWAP) active_bank <= ~active_bank;
      data_out <= active_bank ? bank1[address] : bank0[address];
    end
  end

  // Loads always land in the bank readers are not using
  always_ff @(posedge clk) begin
    if (transfer) begin
      if (active_bank) bank0[wr_addr] <= wr_data;
      else             bank1[wr_addr] <= wr_data;
    end
  end

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [15:0] sum_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_acc  <= '0;
      checksum <= '0;
    end else begin
      if (state == IDLE && start) sum_acc <= '0;
      else if (transfer)          sum_acc <= sum_acc + 16'(wr_data);
      if (transfer && last_word)  checksum <= sum_acc + 16'(wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_activation_lut_loader.sv
// Self-checking bench for activation_lut_loader: transaction-level bank model plus directed load scenarios.
module tb_activation_lut_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = '0;
   logic [7:0] address = '0;
   logic       wr_ready, busy, done, active_bank;
   logic [7:0] data_out;
`ifdef LUT_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   activation_lut_loader #(
      .LUT_FILE   (""),
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .busy        (busy),
      .done        (done),
      .active_bank (active_bank),
`ifdef LUT_LOADER_CHECKSUM_EN
      .checksum    (checksum),
`endif
      .address     (address),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a table load is "256 accepted words after an idle start, then one swap cycle"
   logic [7:0]  m_bank  [2][256];
   bit          m_known [2][256];
   bit          m_loading = 0, m_swap = 0, m_act = 0;
   int          m_cnt = 0;
   logic [15:0] m_sum = '0;
   logic        e_done = 1'b0;
   logic [7:0]  e_data = '0;
   bit          e_known = 1;
   logic [15:0] e_chk = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_loading = 0; m_swap = 0; m_act = 0;
         e_done = 1'b0; e_data = '0; e_known = 1; e_chk = '0;
      end else begin
         e_data  = m_bank[m_act][address];
         e_known = m_known[m_act][address];
         e_done  = 1'b0;
         if (m_swap) begin
            m_act  = !m_act;
            m_swap = 0;
            e_done = 1'b1;
         end else if (m_loading) begin
            if (wr_valid) begin
               m_bank[!m_act][m_cnt]  = wr_data;
               m_known[!m_act][m_cnt] = 1;
               m_sum = m_sum + 16'(wr_data);
               m_cnt++;
               if (m_cnt == 256) begin
                  m_loading = 0;
                  m_swap    = 1;
                  e_chk     = m_sum;
               end
            end
         end else if (start) begin
            m_loading = 1;
            m_cnt     = 0;
            m_sum     = '0;
         end
      end
   end

   always @(negedge clk) begin
      check("wr_ready", 32'(wr_ready), 32'(m_loading));
      check("busy", 32'(busy), 32'(m_loading || m_swap));
      check("done", 32'(done), 32'(e_done));
      check("active_bank", 32'(active_bank), 32'(m_act));
      if (e_known) check("data_out", 32'(data_out), 32'(e_data));
`ifdef LUT_LOADER_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(e_chk));
`endif
   end

   logic [15:0] lfsr = 16'hACE1;
   bit          sweep_addr = 0;

   function automatic logic [7:0] pat(input int p, input int k);
      case (p)
         0:       return 8'(255 - k);
         1:       return 8'(k) ^ 8'hA5;
         2:       return 8'(k + 3);
         default: return 8'h01;
      endcase
   endfunction

   task automatic run_load(input int p, input bit bp, input bit mid_start, input int abort_at,
                           output int cyc, output int xfers);
      int k;
      bit v;
      k = 0; cyc = 0; xfers = 0;
      start = 1'b1; wr_valid = 1'b0;
      @(negedge clk); cyc = 1; start = 1'b0;
      while (k < 256 && cyc < 3000) begin
         if (abort_at >= 0 && k == abort_at) begin
            #2 rst = 1'b1;
            #1;
            check("abort_active_bank", 32'(active_bank), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_wr_ready", 32'(wr_ready), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_data_out", 32'(data_out), 32'd0);
`ifdef LUT_LOADER_CHECKSUM_EN
            check("abort_checksum", 32'(checksum), 32'd0);
`endif
            wr_valid = 1'b0;
            @(negedge clk);
            #2 rst = 1'b0;
            xfers = k;
            return;
         end
         v = bp ? (lfsr[0] | lfsr[5]) : 1'b1;
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         wr_valid = v;
         wr_data  = pat(p, k);
         start    = mid_start && (k == 50);
         if (sweep_addr) address = 8'(k);
         if (v && wr_ready) k++;
         @(negedge clk); cyc++;
      end
      wr_valid = 1'b0; start = 1'b0; xfers = k;
      while (!done && cyc < 3000) begin
         @(negedge clk); cyc++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   initial begin
      int cyc, xf;
      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_active_bank", 32'(active_bank), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      #2 rst = 1'b0;
      foreach (m_known[b, a]) check("mem_init_unknown", 32'(m_known[b][a]), 32'd0);
      address = 8'd0;   @(negedge clk);
      address = 8'd127; @(negedge clk);
      address = 8'd255; @(negedge clk);

      // Full-throughput load of 255-k into bank 1 while reading address 10
      address = 8'd10;
      run_load(0, 0, 0, -1, cyc, xf);
      check("l1_done_latency", 32'(cyc), 32'd258);
      check("l1_active_bank", 32'(active_bank), 32'd1);
      @(negedge clk);
      check("l1_addr10_new", 32'(data_out), 32'hF5);
      address = 8'd0;   @(negedge clk);
      check("l1_addr0", 32'(data_out), 32'hFF);
      address = 8'd255; @(negedge clk);
      check("l1_addr255", 32'(data_out), 32'h00);

      // Backpressured load with a stray start mid-LOAD; address 10 isolation
      address = 8'd10; @(negedge clk);
      run_load(1, 1, 1, -1, cyc, xf);
      check("l2_transfers", 32'(xf), 32'd256);
      check("l2_addr10_old_in_done", 32'(data_out), 32'hF5);
      check("l2_active_bank", 32'(active_bank), 32'd0);
      @(negedge clk);
      check("l2_addr10_new", 32'(data_out), 32'hAF);

      // Back-to-back loads: second start lands in the done cycle of the first
      sweep_addr = 1;
      run_load(2, 0, 0, -1, cyc, xf);
      check("l3_active_bank", 32'(active_bank), 32'd1);
      run_load(0, 0, 0, -1, cyc, xf);
      check("l4_b2b_latency", 32'(cyc), 32'd258);
      check("l4_active_bank", 32'(active_bank), 32'd0);
      sweep_addr = 0;
      for (int a = 0; a < 256; a += 37) begin
         address = 8'(a); @(negedge clk);
      end
      address = 8'd3; @(negedge clk);
      check("l4_addr3", 32'(data_out), 32'hFC);

      // Reset after 100 transfers, then a full load of 0x01 words
      run_load(3, 0, 0, 100, cyc, xf);
      check("l5_abort_transfers", 32'(xf), 32'd100);
      repeat (2) @(negedge clk);
      run_load(3, 0, 0, -1, cyc, xf);
      check("l6_active_bank", 32'(active_bank), 32'd1);
`ifdef LUT_LOADER_CHECKSUM_EN
      check("l6_checksum", 32'(checksum), 32'h0100);
`endif
      address = 8'd200; @(negedge clk);
      address = 8'd0;   @(negedge clk);
      check("l6_addr200", 32'(data_out), 32'h01);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
